// File: rtl/gselect_arbiter.sv
// Round-robin front end sharing one gselect predictor between two branch-trace
// requesters; returns registered predictions and keeps per-requester statistics.
module gselect_arbiter #(
    parameter int PC_W    = 8,
    parameter int CNT_W   = 16,
    parameter int WARM_BR = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [PC_W-1:0]  req0_pc,
    input  logic             req0_outcome,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [PC_W-1:0]  req1_pc,
    input  logic             req1_outcome,
    output logic             req1_ready,
    input  logic             pause,
    input  logic             clear_stats,
    output logic             pred_enable,
    output logic [PC_W-1:0]  pred_pc,
    output logic             pred_outcome,
    input  logic             pred_prediction,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [PC_W-1:0]  rsp_pc,
    output logic             rsp_prediction,
    output logic             rsp_mispredict,
    output logic [CNT_W-1:0] br_cnt0,
    output logic [CNT_W-1:0] br_cnt1,
    output logic [CNT_W-1:0] mp_cnt0,
    output logic [CNT_W-1:0] mp_cnt1,
    output logic             warm
);
    typedef enum logic [1:0] {ST_WARM, ST_RUN, ST_PAUSED} state_t;

    localparam int WC_W = (WARM_BR < 1) ? 1 : $clog2(WARM_BR + 1);
    localparam logic [WC_W-1:0] WARM_LIM = WC_W'(WARM_BR);

    state_t          state_q, state_d, prior_q, prior_d;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic            last_q, last_d;
    logic            grant, gsel, mispredict;

    logic            rsp_valid_q, rsp_id_q, rsp_pred_q, rsp_mp_q;
    logic [PC_W-1:0] rsp_pc_q;
    logic [CNT_W-1:0] br_q [2];
    logic [CNT_W-1:0] mp_q [2];

    // Ties go to the requester that was not granted most recently.
    always_comb begin
        grant = 1'b0;
        gsel  = 1'b0;
        if (!reset && state_q != ST_PAUSED && !pause) begin
            if (req0_valid && req1_valid) begin
                grant = 1'b1;
                gsel  = ~last_q;
            end else if (req0_valid) begin
                grant = 1'b1;
            end else if (req1_valid) begin
                grant = 1'b1;
                gsel  = 1'b1;
            end
        end
    end

    assign req0_ready   = grant & ~gsel;
    assign req1_ready   = grant & gsel;
    assign pred_enable  = grant;
    assign pred_pc      = grant ? (gsel ? req1_pc : req0_pc) : '0;
    assign pred_outcome = grant & (gsel ? req1_outcome : req0_outcome);
    assign mispredict   = pred_prediction != pred_outcome;

    always_comb begin
        state_d = state_q;
        prior_d = prior_q;
        wcnt_d  = wcnt_q;
        last_d  = grant ? gsel : last_q;
        case (state_q)
            ST_WARM: begin
                if (pause) begin
                    state_d = ST_PAUSED;
                    prior_d = ST_WARM;
                end else begin
                    if (grant) wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_d >= WARM_LIM) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pause) begin
                    state_d = ST_PAUSED;
                    prior_d = ST_RUN;
                end
            end
            ST_PAUSED: if (!pause) state_d = prior_q;
            default:   state_d = ST_WARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_WARM;
            prior_q     <= ST_WARM;
            wcnt_q      <= '0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_pc_q    <= '0;
            rsp_pred_q  <= 1'b0;
            rsp_mp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prior_q     <= prior_d;
            wcnt_q      <= wcnt_d;
            last_q      <= last_d;
            rsp_valid_q <= grant;
            rsp_id_q    <= grant & gsel;
            rsp_pc_q    <= pred_pc;
            rsp_pred_q  <= grant & pred_prediction;
            rsp_mp_q    <= grant & mispredict;
        end
    end

    // Saturating statistics; clear_stats beats a same-cycle increment.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stats
            logic inc_br, inc_mp;
            assign inc_br = grant && (gsel == 1'(gi));
            assign inc_mp = inc_br && mispredict && (state_q == ST_RUN);

            always_ff @(posedge clk) begin
                if (reset || clear_stats) begin
                    br_q[gi] <= '0;
                    mp_q[gi] <= '0;
                end else begin
                    if (inc_br && br_q[gi] != {CNT_W{1'b1}}) br_q[gi] <= br_q[gi] + 1'b1;
                    if (inc_mp && mp_q[gi] != {CNT_W{1'b1}}) mp_q[gi] <= mp_q[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_pc         = rsp_pc_q;
    assign rsp_prediction = rsp_pred_q;
    assign rsp_mispredict = rsp_mp_q;
    assign br_cnt0        = br_q[0];
    assign br_cnt1        = br_q[1];
    assign mp_cnt0        = mp_q[0];
    assign mp_cnt1        = mp_q[1];
    assign warm           = (state_q == ST_WARM);
endmodule

// File: tb/tb_gselect_arbiter.sv
// Directed bench for gselect_arbiter: a scoreboard queue holds expected responses,
// a behavioural model tracks grants, FSM and statistics; a CNT_W=2 copy checks saturation.
module tb_gselect_arbiter;
    logic       clk = 1'b0;
    logic       reset, req0_valid, req0_outcome, req1_valid, req1_outcome;
    logic [7:0] req0_pc, req1_pc;
    logic       pause, clear_stats, pred_prediction;

    logic        req0_ready, req1_ready, pred_enable, pred_outcome;
    logic [7:0]  pred_pc, rsp_pc;
    logic        rsp_valid, rsp_id, rsp_prediction, rsp_mispredict, warm;
    logic [15:0] br_cnt0, br_cnt1, mp_cnt0, mp_cnt1;

    logic        s_req0_ready, s_req1_ready, s_pred_enable, s_pred_outcome;
    logic [7:0]  s_pred_pc, s_rsp_pc;
    logic        s_rsp_valid, s_rsp_id, s_rsp_prediction, s_rsp_mispredict, s_warm;
    logic [1:0]  s_br_cnt0, s_br_cnt1, s_mp_cnt0, s_mp_cnt1;

    always #5 clk = ~clk;

    gselect_arbiter #(.PC_W(8), .CNT_W(16), .WARM_BR(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_pc(req0_pc), .req0_outcome(req0_outcome), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_pc(req1_pc), .req1_outcome(req1_outcome), .req1_ready(req1_ready),
        .pause(pause), .clear_stats(clear_stats),
        .pred_enable(pred_enable), .pred_pc(pred_pc), .pred_outcome(pred_outcome),
        .pred_prediction(pred_prediction),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_pc(rsp_pc),
        .rsp_prediction(rsp_prediction), .rsp_mispredict(rsp_mispredict),
        .br_cnt0(br_cnt0), .br_cnt1(br_cnt1), .mp_cnt0(mp_cnt0), .mp_cnt1(mp_cnt1),
        .warm(warm)
    );

    gselect_arbiter #(.PC_W(8), .CNT_W(2), .WARM_BR(0)) dut_small (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_pc(req0_pc), .req0_outcome(req0_outcome), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_pc(req1_pc), .req1_outcome(req1_outcome), .req1_ready(s_req1_ready),
        .pause(pause), .clear_stats(clear_stats),
        .pred_enable(s_pred_enable), .pred_pc(s_pred_pc), .pred_outcome(s_pred_outcome),
        .pred_prediction(pred_prediction),
        .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_pc(s_rsp_pc),
        .rsp_prediction(s_rsp_prediction), .rsp_mispredict(s_rsp_mispredict),
        .br_cnt0(s_br_cnt0), .br_cnt1(s_br_cnt1), .mp_cnt0(s_mp_cnt0), .mp_cnt1(s_mp_cnt1),
        .warm(s_warm)
    );

    typedef struct {
        logic       id;
        logic [7:0] pc;
        logic       pred;
        logic       mp;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Model state: 0 = WARM, 1 = RUN, 2 = PAUSED.
    int m_state, m_prior, m_wcnt, m_last, m_sbr0;
    int m_br[2];
    int m_mp[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit v0, input logic [7:0] p0, input bit o0,
                        input bit v1, input logic [7:0] p1, input bit o1,
                        input bit pr, input bit pa, input bit clr);
        bit         g, sel, mp, oc;
        logic [7:0] pc;
        rsp_t       e;
        reset = rst; req0_valid = v0; req0_pc = p0; req0_outcome = o0;
        req1_valid = v1; req1_pc = p1; req1_outcome = o1;
        pred_prediction = pr; pause = pa; clear_stats = clr;
        #4;
        g = 1'b0; sel = 1'b0;
        if (!rst && m_state != 2 && !pa) begin
            if (v0 && v1) begin g = 1'b1; sel = (m_last == 0); end
            else if (v0) g = 1'b1;
            else if (v1) begin g = 1'b1; sel = 1'b1; end
        end
        pc = g ? (sel ? p1 : p0) : 8'h00;
        oc = g && (sel ? o1 : o0);
        mp = g && (pr != oc);
        chk("req0_ready", req0_ready, g && !sel);
        chk("req1_ready", req1_ready, g && sel);
        chk("pred_enable", pred_enable, g);
        chk("pred_pc", pred_pc, pc);
        chk("pred_outcome", pred_outcome, oc);
        if (g) sb.push_back('{sel, pc, pr, mp});

        if (rst) begin
            m_state = 0; m_prior = 0; m_wcnt = 0; m_last = 1; m_sbr0 = 0;
            m_br[0] = 0; m_br[1] = 0; m_mp[0] = 0; m_mp[1] = 0;
        end else begin
            if (clr) begin
                m_br[0] = 0; m_br[1] = 0; m_mp[0] = 0; m_mp[1] = 0; m_sbr0 = 0;
            end else if (g) begin
                if (m_br[sel] < 65535) m_br[sel]++;
                if (mp && m_state == 1 && m_mp[sel] < 65535) m_mp[sel]++;
                if (!sel && m_sbr0 < 3) m_sbr0++;
            end
            if (g) m_last = sel;
            case (m_state)
                0: if (pa) begin m_state = 2; m_prior = 0; end
                   else begin
                       if (g) m_wcnt++;
                       if (m_wcnt >= 4) m_state = 1;
                   end
                1: if (pa) begin m_state = 2; m_prior = 1; end
                default: if (!pa) m_state = m_prior;
            endcase
        end

        @(posedge clk); #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_pc", rsp_pc, e.pc);
            chk("rsp_prediction", rsp_prediction, e.pred);
            chk("rsp_mispredict", rsp_mispredict, e.mp);
        end else begin
            chk("rsp_valid_idle", rsp_valid, 0);
        end
        chk("br_cnt0", br_cnt0, m_br[0]);
        chk("br_cnt1", br_cnt1, m_br[1]);
        chk("mp_cnt0", mp_cnt0, m_mp[0]);
        chk("mp_cnt1", mp_cnt1, m_mp[1]);
        chk("warm", warm, m_state == 0);
        chk("small_br_cnt0", s_br_cnt0, m_sbr0);
        $display("step rst=%0b v=%0b%0b pause=%0b clr=%0b grant=%0b sel=%0b rsp_valid=%0b br=%0d/%0d mp=%0d/%0d warm=%0b",
                 rst, v0, v1, pa, clr, g, sel, rsp_valid, br_cnt0, br_cnt1, mp_cnt0, mp_cnt1, warm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_state = 0; m_prior = 0; m_wcnt = 0; m_last = 1; m_sbr0 = 0;
        m_br[0] = 0; m_br[1] = 0; m_mp[0] = 0; m_mp[1] = 0;

        // Reset, then a single WARM mispredict on req0.
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        chk("reset_warm", warm, 1);
        chk("reset_br_cnt0", br_cnt0, 0);
        step(0, 1, 8'h05, 1, 0, 8'h00, 0, 0, 0, 0);
        chk("t1_mispredict", rsp_mispredict, 1);
        chk("t1_br_cnt0", br_cnt0, 1);
        chk("t1_mp_cnt0", mp_cnt0, 0);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0);

        // Both valid for 6 cycles after reset: alternation and end of warm-up.
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            step(0, 1, 8'h10 + 8'(i), i[0], 1, 8'h20 + 8'(i), ~i[0], i[1], 0, 0);
        chk("t2_br_cnt0", br_cnt0, 3);
        chk("t2_br_cnt1", br_cnt1, 3);
        chk("t2_warm", warm, 0);

        // RUN-state mispredicts on req1 with clear_stats on the second.
        step(0, 0, 8'h00, 0, 1, 8'h31, 1, 0, 0, 0);
        step(0, 0, 8'h00, 0, 1, 8'h32, 1, 0, 0, 1);
        step(0, 0, 8'h00, 0, 1, 8'h33, 1, 0, 0, 0);
        chk("t3_mp_cnt1", mp_cnt1, 1);
        chk("t3_br_cnt1", br_cnt1, 1);

        // Five req0 grants: the CNT_W=2 copy must hold at 3.
        for (int i = 0; i < 5; i++)
            step(0, 1, 8'h40 + 8'(i), i[0], 0, 8'h00, 0, i[0], 0, 0);
        chk("t4_small_sat", s_br_cnt0, 3);
        chk("t4_br_cnt0", br_cnt0, 5);

        // Pause with both valid, then release; order resumes from last_grant.
        for (int i = 0; i < 3; i++)
            step(0, 1, 8'h50, 1, 1, 8'h60, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++)
            step(0, 1, 8'h51 + 8'(i), 1, 1, 8'h61 + 8'(i), 0, 0, 0, 0);

        // Reset in a grant cycle, pause during warm-up, then a tie goes to req0.
        step(0, 1, 8'h70, 0, 1, 8'h71, 1, 1, 0, 0);
        step(1, 1, 8'h72, 0, 1, 8'h73, 1, 1, 0, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_br_cnt1", br_cnt1, 0);
        step(0, 1, 8'h74, 0, 1, 8'h75, 1, 1, 1, 0);
        step(0, 1, 8'h76, 0, 1, 8'h77, 1, 1, 0, 0);
        step(0, 1, 8'h78, 1, 1, 8'h79, 0, 1, 0, 0);
        chk("t6_first_tie_id", rsp_id, 0);
        step(0, 1, 8'h7a, 1, 1, 8'h7b, 0, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
